// File: rtl/edac_pkg.sv
// Shared types and constants for the EDAC sequencer/arbiter slice.
package edac_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int WR_W_DEF   = 8;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4
  } state_e;

endpackage

// File: rtl/edac_rr_arb2.sv
// Two-requester round-robin arbiter; purely combinational, pointer kept by the parent.
module edac_rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  // Single requester wins outright; on contention the pointer decides.
  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    case (req)
      2'b01: begin
        gnt    = 2'b01;
        gnt_id = 1'b0;
      end
      2'b10: begin
        gnt    = 2'b10;
        gnt_id = 1'b1;
      end
      2'b11: begin
        gnt    = rr_ptr ? 2'b10 : 2'b01;
        gnt_id = rr_ptr;
      end
      default: begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/edac_seq_arb.sv
// Sequencer and two-port arbiter driving one EDAC block's en/READ/EDACSEL/DIN strobes.
module edac_seq_arb
  import edac_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int WR_W    = WR_W_DEF,
  parameter int RES_LAT = 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_read,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  output logic [1:0]        req_ready,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic              rsp_read,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              edac_en,
  output logic              edac_read,
  output logic              edac_sel,
  output logic [DATA_W-1:0] edac_din,
  input  logic [DATA_W-1:0] edac_dout
);

  state_e            r_state;
  logic              r_rr_ptr;
  logic              r_id;
  logic              r_op;
  logic [3:0]        r_cnt;

  logic [1:0]        w_gnt;
  logic              w_gnt_id;
  logic              w_sel_read;
  logic [DATA_W-1:0] w_sel_data;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_hs;

  edac_rr_arb2 u_arb (
    .req    (req_valid),
    .rr_ptr (r_rr_ptr),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id)
  );

  assign w_sel_read = req_read[w_gnt_id];
  assign w_sel_data = w_gnt_id ? req_data1 : req_data0;
  assign w_wr_data  = {{(DATA_W-WR_W){1'b0}}, w_sel_data[WR_W-1:0]};
  assign w_hs       = (r_state == ST_IDLE) && (|req_valid);

  // Ready is offered only in IDLE and only to the requester the arbiter picks.
  always_comb begin
    req_ready = 2'b00;
    if ((r_state == ST_IDLE) && !reset) begin
      req_ready = w_gnt;
    end else begin
      req_ready = 2'b00;
    end
  end

  assign busy = (r_state != ST_IDLE);

  // Main sequencer: strobes are loaded one state early so they appear as flop outputs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= 1'b0;
      r_id      <= 1'b0;
      r_op      <= 1'b0;
      r_cnt     <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_read  <= 1'b0;
      rsp_data  <= '0;
      edac_en   <= 1'b0;
      edac_read <= 1'b0;
      edac_sel  <= 1'b0;
      edac_din  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_id      <= w_gnt_id;
            r_op      <= w_sel_read;
            r_rr_ptr  <= ~w_gnt_id;
            edac_en   <= 1'b1;
            edac_sel  <= 1'b0;
            edac_read <= w_sel_read;
            edac_din  <= (w_sel_read == OP_READ) ? w_sel_data : w_wr_data;
            r_state   <= ST_ISSUE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          edac_en  <= 1'b0;
          edac_sel <= 1'b1;
          edac_din <= '0;
          r_state  <= ST_STROBE;
        end
        ST_STROBE: begin
          edac_sel <= 1'b0;
          r_cnt    <= 4'(RES_LAT - 1);
          r_state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_CAPTURE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_CAPTURE: begin
          rsp_data  <= edac_dout;
          rsp_id    <= r_id;
          rsp_read  <= r_op;
          rsp_valid <= 1'b1;
          edac_read <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          edac_en   <= 1'b0;
          edac_sel  <= 1'b0;
          edac_read <= 1'b0;
          edac_din  <= '0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edac_seq_arb.sv
// Directed bench for edac_seq_arb with a stub EDAC block (DOUT = latched DIN ^ 32'hA5A5_0000).
module tb_edac_seq_arb;

  localparam logic [31:0] STUB_K = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_read;
  logic [31:0] req_data0;
  logic [31:0] req_data1;

  logic [1:0]  req_ready,  req_ready_3;
  logic        rsp_valid,  rsp_valid_3;
  logic        rsp_id,     rsp_id_3;
  logic        rsp_read,   rsp_read_3;
  logic [31:0] rsp_data,   rsp_data_3;
  logic        busy,       busy_3;
  logic        edac_en,    edac_en_3;
  logic        edac_read,  edac_read_3;
  logic        edac_sel,   edac_sel_3;
  logic [31:0] edac_din,   edac_din_3;
  logic [31:0] edac_dout,  edac_dout_3;
  logic [31:0] stub_latch, stub_latch_3;

  int n_checks = 0;
  int n_errors = 0;

  edac_seq_arb #(.DATA_W(32), .WR_W(8), .RES_LAT(1)) dut (
    .CLK(clk), .reset(rst), .req_valid(req_valid), .req_read(req_read),
    .req_data0(req_data0), .req_data1(req_data1), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_read(rsp_read), .rsp_data(rsp_data),
    .busy(busy), .edac_en(edac_en), .edac_read(edac_read), .edac_sel(edac_sel),
    .edac_din(edac_din), .edac_dout(edac_dout)
  );

  edac_seq_arb #(.DATA_W(32), .WR_W(8), .RES_LAT(3)) dut3 (
    .CLK(clk), .reset(rst), .req_valid(req_valid), .req_read(req_read),
    .req_data0(req_data0), .req_data1(req_data1), .req_ready(req_ready_3),
    .rsp_valid(rsp_valid_3), .rsp_id(rsp_id_3), .rsp_read(rsp_read_3), .rsp_data(rsp_data_3),
    .busy(busy_3), .edac_en(edac_en_3), .edac_read(edac_read_3), .edac_sel(edac_sel_3),
    .edac_din(edac_din_3), .edac_dout(edac_dout_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (edac_en) stub_latch <= edac_din;
    edac_dout <= stub_latch ^ STUB_K;
    if (edac_en_3) stub_latch_3 <= edac_din_3;
    edac_dout_3 <= stub_latch_3 ^ STUB_K;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic single_txn(input string tag, input int port, input logic rd,
                            input logic [31:0] data, input logic [31:0] exp_din,
                            input logic [31:0] exp_rsp);
    int  k;
    int  en_n;
    int  sel_n;
    bit  got;
    @(negedge clk);
    req_valid = (port == 0) ? 2'b01 : 2'b10;
    req_read  = rd ? req_valid : 2'b00;
    if (port == 0) req_data0 = data; else req_data1 = data;
    #1 check({tag, ".ready"}, req_ready, (port == 0) ? 2'b01 : 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    check({tag, ".iss_en"}, edac_en, 1);
    check({tag, ".iss_sel"}, edac_sel, 0);
    check({tag, ".iss_read"}, edac_read, rd);
    check({tag, ".iss_din"}, edac_din, exp_din);
    check({tag, ".busy_ready"}, {busy, req_ready}, 3'b100);
    en_n = 1;
    sel_n = 0;
    @(negedge clk);
    check({tag, ".stb"}, {edac_en, edac_sel, edac_read}, {2'b01, rd});
    check({tag, ".stb_din"}, edac_din, 0);
    sel_n = 1;
    @(negedge clk);
    check({tag, ".wait"}, {edac_en, edac_sel, edac_read}, {2'b00, rd});
    k = 3;
    got = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (rsp_valid) got = 1;
      else begin
        en_n  += int'(edac_en);
        sel_n += int'(edac_sel);
      end
    end
    check({tag, ".rsp_seen"}, got, 1);
    check({tag, ".latency"}, k - 1, 4);
    check({tag, ".rsp_id"}, rsp_id, port);
    check({tag, ".rsp_read"}, rsp_read, rd);
    check({tag, ".rsp_data"}, rsp_data, exp_rsp);
    check({tag, ".pulses"}, {en_n[3:0], sel_n[3:0]}, 8'h11);
    @(negedge clk);
    check({tag, ".rsp_one_cycle"}, {rsp_valid, busy}, 2'b00);
  endtask

  initial begin
    int k;
    int n_rsp;
    int rsp_k[3];
    logic rsp_i[3];
    logic [31:0] rsp_d[3];
    logic rsp_r[3];
    bit bad_ready;
    bit got;
    int en_n;
    int sel_n;

    rst = 1'b1;
    req_valid = 2'b00;
    req_read = 2'b00;
    req_data0 = 32'h0;
    req_data1 = 32'h0;
    stub_latch = 32'h0;
    stub_latch_3 = 32'h0;
    #2;
    check("reset.outs", {req_ready, rsp_valid, rsp_id, rsp_read, busy, edac_en, edac_read, edac_sel}, 0);
    check("reset.data", rsp_data | edac_din, 0);
    do_reset();

    // 1: port 0 write; upper payload bits must be masked off DIN
    single_txn("t1", 0, 1'b0, 32'h1234_00B1, 32'h0000_00B1, 32'hA5A5_00B1);

    // 2: port 1 read
    single_txn("t2", 1, 1'b1, 32'h0016_9B13, 32'h0016_9B13, 32'hA5B3_9B13);

    // 3: simultaneous requests from reset
    do_reset();
    @(negedge clk);
    req_valid = 2'b11;
    req_read  = 2'b01;
    req_data0 = 32'h0016_8B13;
    req_data1 = 32'h0000_00B0;
    #1 check("t3.ready0", req_ready, 2'b01);
    n_rsp = 0;
    bad_ready = 0;
    for (int c = 1; c <= 20 && n_rsp < 2; c++) begin
      @(negedge clk);
      if (c == 1) req_valid[0] = 1'b0;
      if (edac_en && edac_din == 32'h0000_00B0) req_valid[1] = 1'b0;
      if (busy && req_ready != 2'b00) bad_ready = 1;
      if (c == 5) check("t3.ready1", req_ready, 2'b10);
      if (rsp_valid) begin
        rsp_k[n_rsp] = c; rsp_i[n_rsp] = rsp_id; rsp_d[n_rsp] = rsp_data; rsp_r[n_rsp] = rsp_read;
        n_rsp++;
      end
    end
    req_valid = 2'b00;
    check("t3.n_rsp", n_rsp, 2);
    check("t3.ready_busy", bad_ready, 0);
    if (n_rsp == 2) begin
      check("t3.first", {rsp_i[0], rsp_r[0]}, 2'b01);
      check("t3.first_data", rsp_d[0], 32'hA5B3_8B13);
      check("t3.second", {rsp_i[1], rsp_r[1]}, 2'b10);
      check("t3.second_data", rsp_d[1], 32'hA5A5_00B0);
      check("t3.lat", rsp_k[0] - 1, 4);
      check("t3.spacing", rsp_k[1] - rsp_k[0], 5);
    end

    // 4: port 0 held valid, port 1 joins mid-transaction
    do_reset();
    @(negedge clk);
    req_valid = 2'b01;
    req_read  = 2'b10;
    req_data0 = 32'hFFFF_FF11;
    req_data1 = 32'h1234_5678;
    n_rsp = 0;
    for (int c = 1; c <= 30 && n_rsp < 3; c++) begin
      @(negedge clk);
      if (c == 2) req_valid[1] = 1'b1;
      if (edac_en && edac_din == 32'h1234_5678) req_valid[1] = 1'b0;
      if (c == 5) check("t4.ready_p1", req_ready, 2'b10);
      if (rsp_valid) begin
        rsp_k[n_rsp] = c; rsp_i[n_rsp] = rsp_id; rsp_d[n_rsp] = rsp_data; rsp_r[n_rsp] = rsp_read;
        n_rsp++;
      end
    end
    req_valid = 2'b00;
    check("t4.n_rsp", n_rsp, 3);
    if (n_rsp == 3) begin
      check("t4.ids", {rsp_i[0], rsp_i[1], rsp_i[2]}, 3'b010);
      check("t4.d0", rsp_d[0], 32'hA5A5_0011);
      check("t4.d1", rsp_d[1], 32'hB791_5678);
      check("t4.spacing", rsp_k[2] - rsp_k[1], 5);
    end
    @(negedge clk);
    @(negedge clk);

    // 5: reset asserted during WAIT
    @(negedge clk);
    req_valid = 2'b01;
    req_read  = 2'b01;
    req_data0 = 32'hCAFE_0001;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("t5.pre_wait", {busy, edac_read, edac_en, edac_sel}, 4'b1100);
    #1 rst = 1'b1;
    #1;
    check("t5.async_outs", {req_ready, rsp_valid, rsp_id, rsp_read, busy, edac_en, edac_read, edac_sel}, 0);
    check("t5.async_data", rsp_data | edac_din, 0);
    @(negedge clk);
    rst = 1'b0;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid || busy) got = 1;
    end
    check("t5.no_rsp", got, 0);
    single_txn("t5b", 0, 1'b1, 32'h0000_1234, 32'h0000_1234, 32'hA5A5_1234);

    // 6: RES_LAT = 3 instance
    do_reset();
    @(negedge clk);
    req_valid = 2'b01;
    req_read  = 2'b00;
    req_data0 = 32'h0000_005A;
    @(negedge clk);
    req_valid = 2'b00;
    k = 1;
    en_n = int'(edac_en_3);
    sel_n = int'(edac_sel_3);
    got = 0;
    while (!got && k < 30) begin
      @(negedge clk);
      k++;
      if (rsp_valid_3) got = 1;
      else begin
        en_n  += int'(edac_en_3);
        sel_n += int'(edac_sel_3);
      end
    end
    check("t6.rsp_seen", got, 1);
    check("t6.latency", k - 1, 6);
    check("t6.rsp_data", rsp_data_3, 32'hA5A5_005A);
    check("t6.pulses", {en_n[3:0], sel_n[3:0]}, 8'h11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/edac_seq_arb.md
Name: edac_seq_arb

Overview:
- Sequencer and two-port arbiter in front of one EDAC_BLOCK instance.
- Accepts encode (write) and decode (read) requests from two requesters: port 0 is the CPU/IO path, port 1 is the memory scrubber.
- Grants the EDAC_BLOCK to one requester at a time and drives its en/READ/EDACSEL/DIN strobe sequence.
- Captures DOUT after a fixed latency and returns it tagged with the requester ID.

Parameters:
- DATA_W, 32, width of EDAC_BLOCK DIN/DOUT and of request/response data.
- WR_W, 8, significant low bits of write (encode) data; upper DATA_W-WR_W bits of DIN are driven 0 on writes.
- RES_LAT, 1, cycles between the EDACSEL strobe cycle and the DOUT capture edge; legal range 1..15.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_read  in  2  per-requester operation: 1 = decode a codeword, 0 = encode data.
- req_data0  in  DATA_W  requester 0 payload.
- req_data1  in  DATA_W  requester 1 payload.
- req_ready  out  1x2  per-requester accept; a request transfers when valid & ready are both high.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  1  requester that owns the response.
- rsp_read  out  1  operation type of the response.
- rsp_data  out  DATA_W  captured EDAC_BLOCK DOUT.
- busy  out  1  high whenever the FSM is not in IDLE.
- edac_en  out  1  to EDAC_BLOCK en.
- edac_read  out  1  to EDAC_BLOCK READ.
- edac_sel  out  1  to EDAC_BLOCK EDACSEL.
- edac_din  out  DATA_W  to EDAC_BLOCK DIN.
- edac_dout  in  DATA_W  from EDAC_BLOCK DOUT.

Behaviour:
- Reset (async assert) forces all outputs and state to 0:
  - FSM = IDLE, rr_ptr = 0, rsp_*/edac_* = 0, req_ready = 0, busy = 0.
  - Any in-flight transaction is dropped and no response is issued.
- FSM states: IDLE -> ISSUE -> STROBE -> WAIT -> CAPTURE -> IDLE.
- IDLE:
  - req_ready[i] = 1 only for the requester the arbiter would grant this cycle; the other bit is 0.
  - On handshake, register the granted id, op and data, then go to ISSUE.
  - With no valid request, stay in IDLE.
- Arbitration:
  - One request pending: it is granted.
  - Both pending: grant rr_ptr.
  - After every grant, rr_ptr = ~granted_id.
  - Two requesters are therefore never granted twice in a row while the other waits.
- ISSUE (1 cycle):
  - edac_en = 1, edac_sel = 0, edac_read = op.
  - edac_din = data for a read; {0, data[WR_W-1:0]} for a write.
- STROBE (1 cycle): edac_en = 0, edac_sel = 1, edac_din = 0, edac_read holds op.
- WAIT: all edac_* strobes 0, edac_read held. A 4-bit counter loads RES_LAT-1 on entry and decrements; exit to CAPTURE when it is 0. With RES_LAT = 1, WAIT lasts 1 cycle.
- CAPTURE (1 cycle):
  - rsp_data <= edac_dout, rsp_id <= id, rsp_read <= op, rsp_valid = 1 for exactly this cycle.
  - The next state is IDLE; the earliest next ISSUE is 2 cycles after CAPTURE.
- Latency from handshake edge to rsp_valid = 3 + RES_LAT cycles (4 at default).
- Throughput: one transaction per 4 + RES_LAT cycles.
- While busy, req_ready = 0. Requesters must hold valid, read and data stable until accepted; changes before acceptance are not errors.
- Registered outputs: edac_* and rsp_* are driven from flops, never combinationally from req_*.
- req_valid may drop without a handshake: allowed, nothing is recorded.

Decomposition:
- Shared package edac_pkg holds:
  - FSM state enum (IDLE, ISSUE, STROBE, WAIT, CAPTURE, 3-bit encoding).
  - Constants OP_WRITE = 0 and OP_READ = 1.
  - The DATA_W/WR_W defaults.
- One natural sub-module: edac_rr_arb2, a 2-requester round-robin arbiter with inputs req[1:0] and rr_ptr, outputs gnt[1:0] and gnt_id. It is purely combinational; rr_ptr lives in the parent.

Test Plan:
All scenarios use a stub EDAC_BLOCK whose DOUT is registered to (DIN latched on en) XOR 32'hA5A5_0000, with RES_LAT = 1.
1. Port 0 write of 8'hB1:
   - ISSUE shows en = 1, READ = 0, DIN = 32'h000000B1; next cycle EDACSEL = 1, DIN = 0.
   - rsp_valid occurs 4 cycles after the handshake with rsp_id = 0, rsp_read = 0, rsp_data = 32'hA5A500B1.
2. Port 1 read of 32'h00169B13 -> edac_read = 1 through ISSUE to WAIT; rsp_id = 1, rsp_data = 32'hA5B39B13.
3. Both ports valid in the same cycle from reset:
   - Port 0 is granted first (read 32'h00168B13), then port 1 (write 8'hB0).
   - Responses arrive in order id 0 then id 1, 5 cycles apart; req_ready stays 0 throughout busy.
4. Port 0 held valid continuously with port 1 asserting mid-transaction -> next grant goes to port 1, proving no starvation.
5. Assert reset during WAIT -> all outputs read 0 immediately (asynchronously); no rsp_valid pulse follows; a subsequent request completes normally.
6. Rebuild with RES_LAT = 3 -> handshake-to-rsp_valid latency is 6 cycles; edac_en/edac_sel pulse exactly once each per transaction.
